// File: rtl/spi_routine_arbiter.sv
// rtl/spi_routine_arbiter.sv - round-robin owner of the single spi_top routine interface
//
// Purpose: lets N_REQ requesters share one ADS1256 routine port. It grants one
// requester at a time in round-robin order, forwards that owner's routine and
// continuous-mode stop, captures the conversion word at completion tagged with
// the owner, and forces a stop when a routine overruns TIMEOUT_CYCLES.
//
// Ports:
//   clock_i, reset_i        single clock, synchronous active-high reset
//   req_start_i[N_REQ]      request levels, held until the matching req_done_o
//   req_routine_i[N_REQ]    routine per requester, sampled at grant only
//   req_stop_i[N_REQ]       continuous-mode stop levels (owner's is forwarded)
//   req_done_o[N_REQ]       one-cycle completion pulse to the owner
//   req_timeout_o[N_REQ]    with req_done_o: routine was ended by the watchdog
//   grant_o[N_REQ]          one-hot owner, zero when idle
//   routine_start_o         start pulse to spi_top
//   routine_o               routine to spi_top, held for the whole grant
//   continuous_stop_o       stop to spi_top
//   routine_done_i, data_i  completion and conversion word from spi_top
//   sample_o, sample_tag_o, sample_valid_o  captured word, owner tag, update pulse

package spi_routine_pkg;
  typedef enum logic [2:0] {
    RT_RESET,
    RT_SELFCAL,
    RT_RDATA,
    RT_RDATAC,
    RT_RREG,
    RT_WREG,
    RT_SYNC,
    RT_STANDBY
  } routine_t;
endpackage

module spi_routine_arbiter
  import spi_routine_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  localparam int TAG_W         = $clog2(N_REQ),
  localparam int SUM_W         = TAG_W + 1,
  localparam int CNT_W         = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [N_REQ-1:0]  req_start_i,
  input  routine_t          req_routine_i [N_REQ],
  input  logic [N_REQ-1:0]  req_stop_i,
  output logic [N_REQ-1:0]  req_done_o,
  output logic [N_REQ-1:0]  req_timeout_o,
  output logic [N_REQ-1:0]  grant_o,
  output logic              routine_start_o,
  output routine_t          routine_o,
  output logic              continuous_stop_o,
  input  logic              routine_done_i,
  input  logic [23:0]       data_i,
  output logic [23:0]       sample_o,
  output logic [TAG_W-1:0]  sample_tag_o,
  output logic              sample_valid_o
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ABORT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   rr_q, rr_d;
  logic [TAG_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               timeout_q, timeout_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  routine_t           routine_q, routine_d;
  logic               stop_q, stop_d;
  logic [23:0]        sample_q, sample_d;
  logic [TAG_W-1:0]   tag_q, tag_d;

  logic               arb_found;
  logic [TAG_W-1:0]   arb_pick;
  logic [SUM_W-1:0]   arb_sum;
  logic [TAG_W-1:0]   arb_cand;

  // Scan downward so the last hit written is the first pending index at or
  // after rr_q, wrapping past N_REQ-1.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    arb_sum   = '0;
    arb_cand  = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      arb_sum = {1'b0, rr_q} + SUM_W'(i);
      if (arb_sum >= SUM_W'(N_REQ)) begin
        arb_sum = arb_sum - SUM_W'(N_REQ);
      end
      arb_cand = arb_sum[TAG_W-1:0];
      if (req_start_i[arb_cand]) begin
        arb_found = 1'b1;
        arb_pick  = arb_cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    grant_d   = grant_q;
    routine_d = routine_q;
    sample_d  = sample_q;
    tag_d     = tag_q;

    unique case (state_q)
      S_IDLE: begin
        if (arb_found) begin
          owner_d   = arb_pick;
          grant_d   = N_REQ'(1) << arb_pick;
          routine_d = req_routine_i[arb_pick];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
        if (routine_done_i) begin
          sample_d = data_i;
          tag_d    = owner_q;
          state_d  = S_DONE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A done arriving on the expiry cycle wins over the timeout.
        if (routine_done_i) begin
          sample_d = data_i;
          tag_d    = owner_q;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES)) begin
          timeout_d = 1'b1;
          state_d   = S_ABORT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ABORT: begin
        // No second watchdog: wait for spi_top to finish the stop.
        if (routine_done_i) begin
          sample_d = data_i;
          tag_d    = owner_q;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        rr_d      = (owner_q == TAG_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        grant_d   = '0;
        timeout_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    stop_d = (((state_q == S_ISSUE) || (state_q == S_WAIT)) && req_stop_i[owner_q])
             || (state_q == S_ABORT);
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      grant_q   <= '0;
      routine_q <= RT_RESET;
      stop_q    <= 1'b0;
      sample_q  <= '0;
      tag_q     <= '0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      grant_q   <= grant_d;
      routine_q <= routine_d;
      stop_q    <= stop_d;
      sample_q  <= sample_d;
      tag_q     <= tag_d;
    end
  end

  // grant_q still names the owner during DONE; it clears on the way to IDLE.
  assign req_done_o        = (state_q == S_DONE) ? grant_q : '0;
  assign req_timeout_o     = ((state_q == S_DONE) && timeout_q) ? grant_q : '0;
  assign grant_o           = grant_q;
  assign routine_start_o   = (state_q == S_ISSUE);
  assign routine_o         = routine_q;
  assign continuous_stop_o = stop_q;
  assign sample_o          = sample_q;
  assign sample_tag_o      = tag_q;
  assign sample_valid_o    = (state_q == S_DONE);

endmodule

// File: tb/tb_spi_routine_arbiter.sv
// tb/tb_spi_routine_arbiter.sv - self-checking bench for spi_routine_arbiter
module tb_spi_routine_arbiter;
  import spi_routine_pkg::*;

  localparam int N   = 2;
  localparam int TMO = 16;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic [N-1:0]  req_start, req_stop, req_done, req_timeout, grant;
  routine_t      req_routine [N];
  logic          routine_start, continuous_stop, routine_done, sample_valid;
  routine_t      routine;
  logic [23:0]   data, sample;
  logic [0:0]    sample_tag;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clock_i = ~clock_i;
  always @(posedge clock_i) cyc <= cyc + 1;

  spi_routine_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .clock_i          (clock_i),
    .reset_i          (reset_i),
    .req_start_i      (req_start),
    .req_routine_i    (req_routine),
    .req_stop_i       (req_stop),
    .req_done_o       (req_done),
    .req_timeout_o    (req_timeout),
    .grant_o          (grant),
    .routine_start_o  (routine_start),
    .routine_o        (routine),
    .continuous_stop_o(continuous_stop),
    .routine_done_i   (routine_done),
    .data_i           (data),
    .sample_o         (sample),
    .sample_tag_o     (sample_tag),
    .sample_valid_o   (sample_valid)
  );

  typedef struct {
    int          req;
    routine_t    rt;
    int          lat;
    logic [23:0] data;
    logic        exp_to;
  } txn_t;

  task automatic tick();
    @(negedge clock_i);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_grant"},   grant, 0);
    chk({tag, "_start"},   routine_start, 0);
    chk({tag, "_done"},    req_done, 0);
    chk({tag, "_timeout"}, req_timeout, 0);
    chk({tag, "_stop"},    continuous_stop, 0);
    chk({tag, "_valid"},   sample_valid, 0);
    chk({tag, "_sample"},  sample, 0);
    chk({tag, "_tag"},     sample_tag, 0);
    chk({tag, "_routine"}, routine, RT_RESET);
  endtask

  task automatic do_reset();
    reset_i      = 1'b1;
    req_start    = '0;
    req_stop     = '0;
    routine_done = 1'b0;
    data         = '0;
    tick();
    reset_i = 1'b0;
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int from);
    for (int i = 0; i < N; i++) begin
      if (r[(from + i) % N]) return (from + i) % N;
    end
    return 0;
  endfunction

  // Start of routine at cycle s, done driven at s+lat, pulse at s+lat+1.
  // The watchdog expires at s+TMO+1 and ABORT begins at s+TMO+2.
  task automatic run_txn(input txn_t t);
    logic [N-1:0] oh;
    oh = N'(1) << t.req;
    req_start[t.req]   = 1'b1;
    req_routine[t.req] = t.rt;
    tick();
    chk("txn_start",   routine_start, 1);
    chk("txn_grant",   grant, oh);
    chk("txn_routine", routine, t.rt);
    req_routine[t.req] = routine_t'(t.rt ^ 3'd5);
    for (int i = 0; i <= t.lat; i++) begin
      if (i > 0) begin
        tick();
        chk("txn_busy_start", routine_start, 0);
        chk("txn_busy_done",  req_done, 0);
        chk("txn_stop",       continuous_stop, (i - 1 >= TMO + 2));
      end
      routine_done = (i == t.lat);
      data         = (i == t.lat) ? t.data : 24'($urandom);
    end
    tick();
    routine_done     = 1'b0;
    req_start[t.req] = 1'b0;
    chk("txn_done",      req_done, oh);
    chk("txn_timeout",   req_timeout, t.exp_to ? oh : '0);
    chk("txn_valid",     sample_valid, 1);
    chk("txn_sample",    sample, t.data);
    chk("txn_tag",       sample_tag, t.req);
    chk("txn_stop_done", continuous_stop, (t.lat >= TMO + 2));
    chk("txn_held",      routine, t.rt);
    tick();
    chk("txn_idle_grant", grant, 0);
    chk("txn_idle_done",  req_done, 0);
    chk("txn_idle_valid", sample_valid, 0);
    chk("txn_idle_start", routine_start, 0);
    chk("txn_idle_stop",  continuous_stop, 0);
  endtask

  txn_t tbl [5];

  // reference model state for the random phase
  logic        m_idle, m_op, m_donep, m_start_due, m_stop_due;
  logic        n_idle, n_op, n_donep, n_start, n_stop, done_now, seen;
  int          m_own, m_lat, m_rr, d_cyc, exp_own;
  routine_t    m_rt;
  logic [23:0] m_data;
  logic [N-1:0] exp_oh;

  initial begin
    tbl[0] = '{req: 0, rt: RT_RDATA,   lat: 10,      data: 24'hABCDEF, exp_to: 1'b0};
    tbl[1] = '{req: 1, rt: RT_SELFCAL, lat: 0,       data: 24'h123456, exp_to: 1'b0};
    tbl[2] = '{req: 0, rt: RT_RREG,    lat: TMO + 1, data: 24'h0F0F0F, exp_to: 1'b0};
    tbl[3] = '{req: 1, rt: RT_RDATAC,  lat: TMO + 7, data: 24'h5A5A5A, exp_to: 1'b1};
    tbl[4] = '{req: 0, rt: RT_WREG,    lat: 3,       data: 24'hFEDCBA, exp_to: 1'b0};
    for (int k = 0; k < N; k++) req_routine[k] = RT_RESET;

    // reset state
    do_reset();
    chk_reset_outputs("reset");

    // fairness: both requesting, each re-asserting after its done
    req_start = 2'b11;
    for (int g = 0; g < 4; g++) begin
      exp_own = g % 2;
      seen = 1'b0;
      for (int w = 0; w < 10 && !seen; w++) begin
        tick();
        seen = routine_start;
      end
      chk("fair_seen",  seen, 1);
      chk("fair_owner", grant, N'(1) << exp_own);
      if (g > 0) chk("fair_gap", cyc - d_cyc, 3);
      tick();
      tick();
      routine_done = 1'b1;
      data         = 24'(g + 1);
      d_cyc        = cyc;
      tick();
      routine_done = 1'b0;
      chk("fair_done", req_done, N'(1) << exp_own);
      req_start[exp_own] = 1'b0;
      tick();
      req_start[exp_own] = 1'b1;
    end
    do_reset();

    // directed transaction table
    for (int i = 0; i < 5; i++) run_txn(tbl[i]);

    // stop forwarding: only the owner's stop reaches spi_top
    req_start[1]   = 1'b1;
    req_routine[1] = RT_RDATAC;
    tick();
    chk("stop_grant", grant, 2'b10);
    tick();
    tick();
    req_stop[0] = 1'b1;
    tick();
    req_stop[0] = 1'b0;
    chk("stop_nonowner", continuous_stop, 0);
    req_stop[1] = 1'b1;
    tick();
    chk("stop_owner", continuous_stop, 1);
    req_stop[1] = 1'b0;
    tick();
    chk("stop_release", continuous_stop, 0);
    req_stop[1]  = 1'b1;
    routine_done = 1'b1;
    data         = 24'h777777;
    tick();
    routine_done = 1'b0;
    chk("stop_done", req_done, 2'b10);
    chk("stop_done_timeout", req_timeout, 0);
    req_start[1] = 1'b0;
    req_stop[1]  = 1'b0;
    tick();

    // reset in the middle of WAIT
    req_start[1] = 1'b1;
    tick();
    chk("rst_grant", grant, 2'b10);
    tick();
    tick();
    reset_i = 1'b1;
    tick();
    chk_reset_outputs("rst_mid");
    reset_i      = 1'b0;
    req_start[0] = 1'b1;
    tick();
    chk("rst_regrant_start", routine_start, 1);
    chk("rst_regrant_owner", grant, 2'b01);
    chk("rst_no_done",       req_done, 0);

    // randomized traffic against a transaction-level model
    do_reset();
    m_idle = 1'b1; m_op = 1'b0; m_donep = 1'b0;
    m_start_due = 1'b0; m_stop_due = 1'b0;
    m_own = 0; m_rr = 0; m_lat = 0; m_data = '0; m_rt = RT_RESET;
    for (int c = 0; c < 600; c++) begin
      if (c > 0) tick();
      exp_oh = N'(1) << m_own;
      chk("rnd_grant",   grant, (m_op || m_donep) ? exp_oh : '0);
      chk("rnd_start",   routine_start, m_start_due);
      chk("rnd_done",    req_done, m_donep ? exp_oh : '0);
      chk("rnd_valid",   sample_valid, m_donep);
      chk("rnd_timeout", req_timeout, 0);
      chk("rnd_stop",    continuous_stop, m_stop_due);
      if (m_start_due) chk("rnd_routine", routine, m_rt);
      if (m_donep) begin
        chk("rnd_sample", sample, m_data);
        chk("rnd_tag",    sample_tag, m_own);
      end

      done_now = 1'b0;
      if (m_op) begin
        if (m_lat == 0) done_now = 1'b1;
        else m_lat--;
      end else begin
        done_now = ($urandom_range(3) == 0);
      end
      routine_done = done_now;
      data         = 24'($urandom);
      if (m_op && done_now) m_data = data;
      for (int k = 0; k < N; k++) begin
        if (m_donep && k == m_own) req_start[k] = 1'b0;
        else if (!req_start[k]) req_start[k] = ($urandom_range(2) == 0);
        else if (!(m_op && k == m_own) && $urandom_range(9) == 0) req_start[k] = 1'b0;
        req_routine[k] = routine_t'($urandom_range(7));
      end
      req_stop = N'($urandom);

      n_stop  = m_op && req_stop[m_own];
      n_start = 1'b0;
      n_idle  = m_idle;
      n_op    = m_op;
      n_donep = 1'b0;
      if (m_idle && (req_start != '0)) begin
        m_own   = rr_pick(req_start, m_rr);
        m_rr    = (m_own + 1) % N;
        m_rt    = req_routine[m_own];
        m_lat   = $urandom_range(5);
        n_idle  = 1'b0;
        n_op    = 1'b1;
        n_start = 1'b1;
      end
      if (m_op && done_now) begin
        n_op    = 1'b0;
        n_donep = 1'b1;
      end
      if (m_donep) n_idle = 1'b1;
      m_idle = n_idle; m_op = n_op; m_donep = n_donep;
      m_start_due = n_start; m_stop_due = n_stop;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
